pipe_stage_reg: RTL and testbench
=================================

# pipe_stage_reg

Parametrised pipeline-boundary register that replaces the per-stage hand-written latches (IF/ID, ID/EX, EX/MEM, MEM/WB) with one block. It carries an arbitrary-width payload plus a valid bit and follows the core's 6-bit stall-vector protocol: hold, bubble insertion and normal advance. It adds a synchronous flush for exception/branch squash, a sticky protocol-error flag, and saturating stall/bubble performance counters. One instance sits at each stage boundary, driven by the central stall controller.

## Interface
- DATA_W, 64: payload width in bits (≥1).
- STAGE, 2: index of the upstream stage; stall[STAGE] = upstream stalled, stall[STAGE+1] = downstream stalled. Legal range 0..STALL_W-2.
- STALL_W, 6: stall vector width.
- NOP_VALUE, {DATA_W{1'b0}}: payload loaded on reset, flush, bubble or invalid input.
- CNT_W, 16: performance counter width.
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  reset; synchronous, active-high.
- stall  in  STALL_W  stall vector from stall controller; bit = 1 means STOP.
- flush  in  1  squash stage contents this cycle.
- cnt_clr  in  1  synchronous clear of both counters.
- in_valid  in  1  upstream payload valid.
- in_data  in  DATA_W  upstream payload.
- out_valid  out  1  registered valid to downstream stage.
- out_data  out  DATA_W  registered payload.
- hold_cnt  out  CNT_W  cycles spent holding (saturating).
- bubble_cnt  out  CNT_W  bubbles inserted (saturating).
- stall_err  out  1  sticky: illegal stall pattern seen.

## Operation
- Let up = stall[STAGE], dn = stall[STAGE+1]. Per-cycle action, strict priority:
  1. rst: out_valid=0, out_data=NOP_VALUE, counters=0, stall_err=0.
  2. flush: out_valid=0, out_data=NOP_VALUE. Overrides hold and bubble. Counters unchanged.
  3. up=1, dn=0 (BUBBLE): out_valid=0, out_data=NOP_VALUE; bubble_cnt += 1.
  4. up=0 (LOAD): out_valid=in_valid; out_data = in_valid ? in_data : NOP_VALUE.
  5. up=1, dn=1 (HOLD): all outputs keep their value; hold_cnt += 1.
- Illegal pattern up=0, dn=1 (the stall controller only asserts contiguous low-order bits): the block performs LOAD, as the legacy stage registers did, and sets stall_err=1. stall_err is cleared only by rst.
- Counters saturate at 2^CNT_W−1 and never wrap. cnt_clr clears both counters. If cnt_clr and an increment coincide, the counter ends at 0.
- Counters do not increment while rst or flush is active.
- Bits of stall other than STAGE and STAGE+1 are ignored.

## Timing
- Latency: one cycle from in_data/in_valid to out_data/out_valid on LOAD.
- All outputs are registered; no combinational path from input to output.
- Reset values: out_valid=0, out_data=NOP_VALUE, hold_cnt=0, bubble_cnt=0, stall_err=0.
- A reset asserted mid-hold discards the held payload in the same edge.
- A flush during HOLD discards the held payload. The next cycle resumes per stall.
- The counters' new values are visible on the cycle after the event.

## Structure
- Shared header pipe.vh holds STALL_W, the STOP/NOT_STOP bit values, and the priority action encodings (ACT_RST, ACT_FLUSH, ACT_BUBBLE, ACT_LOAD, ACT_HOLD) used by the bench monitor.
- Global RST_ENABLE and zero-word constants stay in the global header.
- One sub-module, sat_counter (WIDTH, inc, clr → count), is instantiated twice.

## Test plan
- Reset: rst=1 for 2 cycles with in_valid=1, in_data=0xDEAD_BEEF → out_valid=0, out_data=NOP_VALUE, hold_cnt=bubble_cnt=0.
- Advance: stall=6'b000000, STAGE=2, feed 0x1, 0x2, 0x3 on consecutive cycles → out_data shows 0x1, 0x2, 0x3 one cycle later each, out_valid=1.
- Hold then bubble: load 0xA5; stall=6'b001111 for 3 cycles → out_data stays 0xA5, hold_cnt=3. Then stall=6'b000111 for 1 cycle → out_valid=0, out_data=NOP_VALUE, bubble_cnt=1.
- Flush priority: during HOLD (stall=6'b001111) holding 0x77, pulse flush → next cycle out_valid=0, out_data=NOP_VALUE, hold_cnt not incremented on that edge.
- Illegal stall: stall=6'b001000 with in_data=0x55, in_valid=1 → out_data=0x55, stall_err=1, and stall_err remains 1 until rst.
- Saturation/clear: CNT_W=4, hold 20 cycles → hold_cnt=15. Assert cnt_clr while still holding → hold_cnt=0 next cycle, then 1 the cycle after.

Source files
------------

// File: rtl/pipe_stage_reg_pkg.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | pipe_stage_reg_pkg : stall-vector constants and per-cycle action codes  |
// | Revision: 1.0                                                           |
// +-------------------------------------------------------------------------+
package pipe_stage_reg_pkg;

    localparam int   c_STALL_W  = 6;
    localparam logic c_STOP     = 1'b1;
    localparam logic c_NOT_STOP = 1'b0;

    typedef enum logic [2:0] {
        ACT_RST    = 3'd0,
        ACT_FLUSH  = 3'd1,
        ACT_BUBBLE = 3'd2,
        ACT_LOAD   = 3'd3,
        ACT_HOLD   = 3'd4
    } act_e;

    // Strict priority: reset, flush, bubble, load (incl. illegal up=0/dn=1), hold.
    function automatic act_e next_action(input logic rst, input logic flush,
                                         input logic up, input logic dn);
        act_e act;
        if (rst)
            act = ACT_RST;
        else if (flush)
            act = ACT_FLUSH;
        else if (up == c_STOP && dn == c_NOT_STOP)
            act = ACT_BUBBLE;
        else if (up == c_NOT_STOP)
            act = ACT_LOAD;
        else
            act = ACT_HOLD;
        return act;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pipe_stage_reg_sat_counter.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | sat_counter : saturating up-counter with synchronous clear              |
// | Revision: 1.0                                                           |
// +-------------------------------------------------------------------------+
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] count
);

    localparam logic [WIDTH-1:0] c_MAX = {WIDTH{1'b1}};

    logic [WIDTH-1:0] r_count;

    // Clear wins over a coincident increment.
    always_ff @(posedge clk) begin
        if (rst || clr)
            r_count <= '0;
        else if (inc && r_count != c_MAX)
            r_count <= r_count + 1'b1;
    end

    assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/pipe_stage_reg.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | pipe_stage_reg : pipeline boundary register with hold/bubble/flush      |
// | Revision: 1.0                                                           |
// +-------------------------------------------------------------------------+
module pipe_stage_reg
    import pipe_stage_reg_pkg::*;
#(
    parameter int                DATA_W    = 64,
    parameter int                STAGE     = 2,
    parameter int                STALL_W   = c_STALL_W,
    parameter logic [DATA_W-1:0] NOP_VALUE = {DATA_W{1'b0}},
    parameter int                CNT_W     = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [STALL_W-1:0] stall,
    input  logic               flush,
    input  logic               cnt_clr,
    input  logic               in_valid,
    input  logic [DATA_W-1:0]  in_data,
    output logic               out_valid,
    output logic [DATA_W-1:0]  out_data,
    output logic [CNT_W-1:0]   hold_cnt,
    output logic [CNT_W-1:0]   bubble_cnt,
    output logic               stall_err
);

    logic              w_up;
    logic              w_dn;
    act_e              w_act;
    logic              w_hold_inc;
    logic              w_bubble_inc;
    logic              w_unused_stall;
    logic              r_out_valid;
    logic [DATA_W-1:0] r_out_data;
    logic              r_stall_err;

    assign w_up           = stall[STAGE];
    assign w_dn           = stall[STAGE+1];
    assign w_unused_stall = ^stall;

    always_comb begin
        w_act = next_action(rst, flush, w_up, w_dn);
    end

    assign w_hold_inc   = (w_act == ACT_HOLD);
    assign w_bubble_inc = (w_act == ACT_BUBBLE);

    always_ff @(posedge clk) begin
        case (w_act)
            ACT_LOAD: begin
                r_out_valid <= in_valid;
                r_out_data  <= in_valid ? in_data : NOP_VALUE;
            end
            ACT_HOLD: begin
                r_out_valid <= r_out_valid;
                r_out_data  <= r_out_data;
            end
            default: begin
                r_out_valid <= 1'b0;
                r_out_data  <= NOP_VALUE;
            end
        endcase
    end

    // Sticky until reset; the controller should never drive up=0 with dn=1.
    always_ff @(posedge clk) begin
        if (rst)
            r_stall_err <= 1'b0;
        else if (w_up == c_NOT_STOP && w_dn == c_STOP)
            r_stall_err <= 1'b1;
    end

    sat_counter #(.WIDTH(CNT_W)) u_hold_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (w_hold_inc),
        .clr   (cnt_clr),
        .count (hold_cnt)
    );

    sat_counter #(.WIDTH(CNT_W)) u_bubble_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (w_bubble_inc),
        .clr   (cnt_clr),
        .count (bubble_cnt)
    );

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign stall_err = r_stall_err;

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_reg.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | tb_pipe_stage_reg : directed self-checking bench for pipe_stage_reg     |
// | Revision: 1.0                                                           |
// +-------------------------------------------------------------------------+
module tb_pipe_stage_reg;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  stall;
    logic        flush;
    logic        cnt_clr;
    logic        in_valid;
    logic [63:0] in_data;

    logic        out_valid;
    logic [63:0] out_data;
    logic [15:0] hold_cnt;
    logic [15:0] bubble_cnt;
    logic        stall_err;

    logic        s_out_valid;
    logic [31:0] s_out_data;
    logic [3:0]  s_hold_cnt;
    logic [3:0]  s_bubble_cnt;
    logic        s_stall_err;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    pipe_stage_reg dut (
        .clk        (clk),
        .rst        (rst),
        .stall      (stall),
        .flush      (flush),
        .cnt_clr    (cnt_clr),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .hold_cnt   (hold_cnt),
        .bubble_cnt (bubble_cnt),
        .stall_err  (stall_err)
    );

    pipe_stage_reg #(.DATA_W(32), .CNT_W(4)) dut_small (
        .clk        (clk),
        .rst        (rst),
        .stall      (stall),
        .flush      (flush),
        .cnt_clr    (cnt_clr),
        .in_valid   (in_valid),
        .in_data    (in_data[31:0]),
        .out_valid  (s_out_valid),
        .out_data   (s_out_data),
        .hold_cnt   (s_hold_cnt),
        .bubble_cnt (s_bubble_cnt),
        .stall_err  (s_stall_err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; stall = 6'b000000; flush = 1'b0; cnt_clr = 1'b0;
        in_valid = 1'b1; in_data = 64'hDEAD_BEEF;

        // Reset with live input
        tick(); tick();
        check("rst_valid", out_valid, 0);
        check("rst_data", out_data, 0);
        check("rst_hold", hold_cnt, 0);
        check("rst_bubble", bubble_cnt, 0);
        check("rst_err", stall_err, 0);

        // Advance
        rst = 1'b0;
        in_data = 64'h1; tick();
        check("adv1_data", out_data, 64'h1); check("adv1_valid", out_valid, 1);
        in_data = 64'h2; tick();
        check("adv2_data", out_data, 64'h2); check("adv2_valid", out_valid, 1);
        in_data = 64'h3; tick();
        check("adv3_data", out_data, 64'h3); check("adv3_valid", out_valid, 1);
        in_valid = 1'b0; in_data = 64'h99; tick();
        check("inv_valid", out_valid, 0); check("inv_data", out_data, 0);

        // Hold then bubble
        in_valid = 1'b1; in_data = 64'hA5; tick();
        stall = 6'b001111; in_data = 64'h11;
        tick(); tick(); tick();
        check("hold_data", out_data, 64'hA5); check("hold_valid", out_valid, 1);
        check("hold_cnt3", hold_cnt, 3);
        stall = 6'b000111; tick();
        check("bub_valid", out_valid, 0); check("bub_data", out_data, 0);
        check("bub_cnt1", bubble_cnt, 1); check("bub_hold3", hold_cnt, 3);

        // Flush during hold
        stall = 6'b000000; in_data = 64'h77; tick();
        stall = 6'b001111; in_data = 64'h12; tick();
        check("fl_pre_data", out_data, 64'h77); check("fl_pre_hold", hold_cnt, 4);
        flush = 1'b1; tick();
        check("fl_valid", out_valid, 0); check("fl_data", out_data, 0);
        check("fl_hold", hold_cnt, 4);
        flush = 1'b0; tick();
        check("fl_after_valid", out_valid, 0); check("fl_after_hold", hold_cnt, 5);

        // Unrelated stall bits ignored; flush overrides bubble
        stall = 6'b110111; tick();
        check("ign_bubble", bubble_cnt, 2); check("ign_err", stall_err, 0);
        flush = 1'b1; tick();
        check("fl_bub_cnt", bubble_cnt, 2);
        flush = 1'b0;

        // Illegal stall pattern
        stall = 6'b001000; in_valid = 1'b1; in_data = 64'h55; tick();
        check("ill_data", out_data, 64'h55); check("ill_valid", out_valid, 1);
        check("ill_err", stall_err, 1);
        stall = 6'b000000; in_data = 64'h66; tick();
        check("ill_sticky", stall_err, 1); check("ill_next_data", out_data, 64'h66);

        // Reset mid-hold drops payload and clears sticky error
        in_data = 64'hBB; tick();
        stall = 6'b001111; tick();
        rst = 1'b1; tick();
        check("rh_valid", out_valid, 0); check("rh_data", out_data, 0);
        check("rh_err", stall_err, 0); check("rh_hold", hold_cnt, 0);
        rst = 1'b0;

        // Saturation and clear
        for (int i = 0; i < 20; i++) tick();
        check("sat_small", s_hold_cnt, 15); check("sat_big", hold_cnt, 20);
        cnt_clr = 1'b1; tick();
        check("clr_small", s_hold_cnt, 0); check("clr_big", hold_cnt, 0);
        cnt_clr = 1'b0; tick();
        check("clr_next_small", s_hold_cnt, 1); check("clr_next_big", hold_cnt, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
